// File: rtl/uf_pkg.sv
// Shared union-find definitions: node table sizing, edge metadata and the
// root-scan state encoding.
package uf_pkg;

  localparam int MAX_NODE_COUNT  = 2000;
  localparam int INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT);

  typedef struct packed {
    logic [INDEX_BIT_WIDTH-1:0] src;
    logic [INDEX_BIT_WIDTH-1:0] dst;
    logic                       valid;
  } uf_edge_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_MUL1,
    ST_MUL2,
    ST_DONE
  } scan_state_e;

endpackage

// File: rtl/top3_insert.sv
// Combinational insertion of one size into three descending slots t0>=t1>=t2.
// A value equal to an existing entry lands below it.
module top3_insert
  import uf_pkg::*;
#(
  parameter int W = INDEX_BIT_WIDTH
) (
  input  logic [W-1:0] t0,
  input  logic [W-1:0] t1,
  input  logic [W-1:0] t2,
  input  logic [W-1:0] s,
  input  logic         en,
  output logic [W-1:0] t0_nxt,
  output logic [W-1:0] t1_nxt,
  output logic [W-1:0] t2_nxt
);

  always_comb begin
    t0_nxt = t0;
    t1_nxt = t1;
    t2_nxt = t2;
    if (en) begin
      if (s > t0) begin
        t0_nxt = s;
        t1_nxt = t0;
        t2_nxt = t1;
      end else if (s > t1) begin
        t1_nxt = s;
        t2_nxt = t1;
      end else if (s > t2) begin
        t2_nxt = s;
      end
    end
  end

endmodule

// File: rtl/circuit_top3_scan.sv
// Scans every node of the union-find table, keeps the three largest root
// sizes and reports their product together with the number of roots.
module circuit_top3_scan #(
  parameter int  MAX_NODE_COUNT  = uf_pkg::MAX_NODE_COUNT,
  localparam int INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT),
  localparam int PRODUCT_WIDTH   = 3 * INDEX_BIT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [INDEX_BIT_WIDTH:0]   node_count,
  input  logic                       uf_valid,
  output logic [INDEX_BIT_WIDTH-1:0] uf_index,
  input  logic                       uf_is_root,
  input  logic [INDEX_BIT_WIDTH-1:0] uf_size,
  output logic                       busy,
  output logic                       done,
  output logic [PRODUCT_WIDTH-1:0]   product,
  output logic [INDEX_BIT_WIDTH:0]   root_count
);

  import uf_pkg::*;

  localparam logic [INDEX_BIT_WIDTH:0] MAX_CNT = (INDEX_BIT_WIDTH+1)'(MAX_NODE_COUNT);

  scan_state_e                  state;
  logic [INDEX_BIT_WIDTH:0]     count_q;
  logic [INDEX_BIT_WIDTH-1:0]   t0, t1, t2;
  logic [INDEX_BIT_WIDTH-1:0]   t0_nxt, t1_nxt, t2_nxt;
  logic [2*INDEX_BIT_WIDTH-1:0] p;
  logic                         ins_en;
  logic                         last_idx;

  assign ins_en   = (state == ST_SCAN) && uf_valid && uf_is_root;
  assign last_idx = ({1'b0, uf_index} == (count_q - 1'b1));

  top3_insert #(
    .W (INDEX_BIT_WIDTH)
  ) u_insert (
    .t0     (t0),
    .t1     (t1),
    .t2     (t2),
    .s      (uf_size),
    .en     (ins_en),
    .t0_nxt (t0_nxt),
    .t1_nxt (t1_nxt),
    .t2_nxt (t2_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      count_q    <= '0;
      uf_index   <= '0;
      t0         <= '0;
      t1         <= '0;
      t2         <= '0;
      p          <= '0;
      product    <= '0;
      root_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // done is still high in the cycle after DONE, so a start there is refused
          if (start && !done) begin
            uf_index   <= '0;
            t0         <= '0;
            t1         <= '0;
            t2         <= '0;
            product    <= '0;
            root_count <= '0;
            count_q    <= (node_count > MAX_CNT) ? MAX_CNT : node_count;
            busy       <= 1'b1;
            state      <= (node_count == '0) ? ST_MUL1 : ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (uf_valid) begin
            t0 <= t0_nxt;
            t1 <= t1_nxt;
            t2 <= t2_nxt;
            if (uf_is_root) root_count <= root_count + 1'b1;
            // uf_index parks on the last node instead of stepping past it
            if (last_idx) state    <= ST_MUL1;
            else          uf_index <= uf_index + 1'b1;
          end
        end
        ST_MUL1: begin
          p     <= (2*INDEX_BIT_WIDTH)'(t0) * (2*INDEX_BIT_WIDTH)'(t1);
          state <= ST_MUL2;
        end
        ST_MUL2: begin
          product <= PRODUCT_WIDTH'(p) * PRODUCT_WIDTH'(t2);
          state   <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/circuit_top3_scan.md
CIRCUIT_TOP3_SCAN -- requirements
Module: circuit_top3_scan

Interface
REQ-001 SHALL have parameter MAX_NODE_COUNT, default 2000, meaning the node table depth of the upstream union-find.
REQ-002 SHALL have localparams INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT) and PRODUCT_WIDTH = 3*INDEX_BIT_WIDTH.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
REQ-007 node_count  input  INDEX_BIT_WIDTH+1  number of nodes to scan, indices 0..node_count-1.
REQ-008 uf_valid  input  1  union-find read port is valid (finder is idle).
REQ-009 uf_index  output  INDEX_BIT_WIDTH  registered node index presented to the union-find read port.
REQ-010 uf_is_root  input  1  combinational root flag for uf_index.
REQ-011 uf_size  input  INDEX_BIT_WIDTH  combinational tree size for uf_index; meaningful only when uf_is_root=1.
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 done  output  1  one-cycle pulse when the result is valid.
REQ-014 product  output  PRODUCT_WIDTH  product of the three largest root sizes; held until the next start.
REQ-015 root_count  output  INDEX_BIT_WIDTH+1  number of roots seen; held until the next start.

Function
REQ-016 SHALL implement the states IDLE, SCAN, MUL1, MUL2 and DONE.
REQ-017 IDLE: on start=1, SHALL clear uf_index, slots t0/t1/t2, product and root_count; clamp node_count to MAX_NODE_COUNT; go to SCAN, or to MUL1 if node_count=0.
REQ-018 start while not in IDLE SHALL be ignored.
REQ-019 SCAN: in a cycle with uf_valid=1, SHALL sample uf_is_root/uf_size for the current uf_index and advance uf_index by 1.
REQ-020 SCAN: in a cycle with uf_valid=0, SHALL stall with no sample and no advance.
REQ-021 The sample for the last index SHALL transition SCAN to MUL1.
REQ-022 On a sample with uf_is_root=1, SHALL increment root_count and insert uf_size into the descending slots t0>=t1>=t2.
REQ-023 Insertion of size s: s>t0 shifts t0->t1->t2 and sets t0=s; else s>t1 shifts t1->t2 and sets t1=s; else s>t2 sets t2=s; else no change. Ties SHALL land below the existing equal entry.
REQ-024 Empty slots SHALL hold 0, so fewer than three roots yields product=0.
REQ-025 Scan throughput SHALL be one node per cycle while uf_valid=1; latency from start = 1 + node_count + stall cycles + 3.
REQ-026 MUL1 SHALL register p = t0*t1 at 2*INDEX_BIT_WIDTH bits.
REQ-027 MUL2 SHALL register product = p*t2 at PRODUCT_WIDTH bits, with no truncation.
REQ-028 DONE SHALL pulse done for one cycle, deassert busy and return to IDLE.
REQ-029 A start in the same cycle as done SHALL be ignored; the earliest accepted start is the following cycle.
REQ-030 uf_index SHALL never exceed node_count-1 while in SCAN.

Reset
REQ-031 Assertion of rst_n=0 at any time, including mid-scan, SHALL immediately force IDLE and zero uf_index, slots, p, product, root_count, busy and done.
REQ-032 After rst_n deasserts, the block SHALL take no action until a new start.

Structure
REQ-033 MAX_NODE_COUNT, INDEX_BIT_WIDTH and the union-find edge metadata struct SHALL move to a shared package uf_pkg; the scan state enum SHALL be declared there too.
REQ-034 Slot insertion logic SHALL be one combinational sub-module top3_insert (inputs t0,t1,t2,s,en; outputs next t0,t1,t2).
REQ-035 No memories; all state SHALL be in flops.

Verification
REQ-036 node_count=5, roots {0:size 2, 2:size 3}, others non-root -> product=0, root_count=2, done after 9 cycles.
REQ-037 node_count=6, root sizes {1,5,5,2,4,1} all roots -> slots 5,5,4, product=100, root_count=6.
REQ-038 node_count=4, uf_valid low for 3 cycles mid-scan -> same result as unstalled, done delayed exactly 3 cycles.
REQ-039 node_count=0 -> done 4 cycles after start, product=0, root_count=0, no uf_index change.
REQ-040 Full table of MAX_NODE_COUNT=2000 with three roots of size 1999,1999,1999 -> product=7988005999, no overflow.
REQ-041 rst_n pulsed low mid-scan then start with node_count=3 all size 3 -> fresh result product=27, root_count=3.
